fifo_wr_arbiter: RTL and testbench

- Shares the write port of one synchronous FIFO between NUM_REQ packet producers.
- Arbitration is round-robin. A grant locks to one requester until that requester's packet ends, so packets never interleave in the FIFO.
- Sits directly in front of the FIFO write interface. Its outputs drive wr_en and wr_data, and it observes full.
- Enforces a maximum packet length; an over-long packet loses its grant.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/fifo_wr_arbiter_if.sv | 31 +++
 rtl/rr_pick.sv | 46 ++++
 rtl/fifo_wr_arbiter.sv | 104 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared state type and width helpers for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {IDLE, GRANT} arb_state_e;

  function automatic int unsigned id_w(int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int unsigned cnt_w(int unsigned max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signals of the write arbiter, bundled with modports.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned IdW = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_full;
  logic                          grant_valid;
  logic [IdW-1:0]                grant_id;
  logic                          trunc_pulse;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id, trunc_pulse
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id, trunc_pulse
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate by pointer, priority-encode, un-rotate.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdW    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IdW-1:0]     i_ptr,
  output logic [IdW-1:0]     o_winner,
  output logic               o_any
);

  logic [NUM_REQ-1:0] w_rot;
  logic [IdW-1:0]     w_idx;
  logic [31:0]        w_sum;

  // w_rot[i] holds the request that sits i places above the pointer.
  always_comb begin
    w_rot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if ((i + 32'(i_ptr)) % NUM_REQ == j) begin
          w_rot[i] = i_req[j];
        end
      end
    end
  end

  always_comb begin
    w_idx = '0;
    o_any = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_rot[i] && !o_any) begin
        w_idx = IdW'(i);
        o_any = 1'b1;
      end
    end
    w_sum = 32'(w_idx) + 32'(i_ptr);
    if (w_sum >= NUM_REQ) begin
      w_sum = w_sum - NUM_REQ;
    end
    o_winner = IdW'(w_sum);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; grants lock per packet, capped at MAX_BEATS.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BEATS  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  fifo_wr_arbiter_if.slave io_bus
);

  localparam int unsigned IdW  = id_w(NUM_REQ);
  localparam int unsigned CntW = cnt_w(MAX_BEATS);

  arb_state_e      r_state;
  logic [IdW-1:0]  r_rr_ptr;
  logic [IdW-1:0]  r_grant_id;
  logic [CntW-1:0] r_beat_cnt;
  logic            r_trunc;

  logic [IdW-1:0]        w_winner;
  logic [IdW-1:0]        w_next_id;
  logic                  w_any;
  logic                  w_granted;
  logic                  w_valid_g;
  logic                  w_last_g;
  logic                  w_accept;
  logic [NUM_REQ-1:0]    w_ready;
  logic [DATA_WIDTH-1:0] w_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req    (io_bus.req_valid),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_granted = (r_state == GRANT);
  assign w_accept  = w_valid_g && !io_bus.fifo_full;
  assign w_next_id = (r_grant_id == IdW'(NUM_REQ - 1)) ? '0 : r_grant_id + IdW'(1);

  always_comb begin
    w_valid_g = 1'b0;
    w_last_g  = 1'b0;
    w_ready   = '0;
    w_data    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_granted && (r_grant_id == IdW'(i))) begin
        w_valid_g  = io_bus.req_valid[i];
        w_last_g   = io_bus.req_last[i];
        w_ready[i] = !io_bus.fifo_full;
        w_data     = io_bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
      r_trunc    <= 1'b0;
    end else begin
      r_trunc <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant_id <= w_winner;
            r_beat_cnt <= '0;
            r_state    <= GRANT;
          end
        end
        GRANT: begin
          // A dropped valid on the holder is a bubble; only an accepted beat can release.
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + CntW'(1);
            if (w_last_g) begin
              r_state  <= IDLE;
              r_rr_ptr <= w_next_id;
            end else if (r_beat_cnt == CntW'(MAX_BEATS - 1)) begin
              r_state  <= IDLE;
              r_rr_ptr <= w_next_id;
              r_trunc  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.req_ready    = w_ready;
  assign io_bus.fifo_wr_en   = w_accept;
  assign io_bus.fifo_wr_data = w_data;
  assign io_bus.grant_valid  = w_granted;
  assign io_bus.grant_id     = r_grant_id;
  assign io_bus.trunc_pulse  = r_trunc;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: queued producers, a packet-level arbitration model and directed scenarios.
module tb_fifo_wr_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXB = 16;
  localparam int QD   = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MAXB)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  // Producer queues: circular buffers of {data, last} per requester.
  logic [DW-1:0] pdat  [N][QD];
  logic          plast [N][QD];
  int            prd [N];
  int            pwr [N];
  bit            bubble [N];
  logic          full;

  // Behavioural model: who holds the grant, beats taken, where the next search starts.
  int m_holder, m_gid, m_cnt, m_next;
  bit m_trunc;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int cyc = 0;
  int first_trunc_at;
  int trunc_cnt;
  logic [DW-1:0] log_data [$];
  int            log_id   [$];
  int            log_cyc  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout waiting, got no event expected one at %0t", name, $time);
  endtask

  task automatic model_reset();
    m_holder = -1;
    m_gid    = 0;
    m_cnt    = 0;
    m_next   = 0;
    m_trunc  = 1'b0;
  endtask

  task automatic compare_cycle(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                               input logic full_s);
    logic [N-1:0]  e_rdy;
    logic          e_wr;
    logic [DW-1:0] e_data;
    e_rdy  = '0;
    e_wr   = 1'b0;
    e_data = '0;
    if (m_holder >= 0) begin
      if (!full_s) e_rdy[m_holder] = 1'b1;
      e_wr   = v[m_holder] && !full_s;
      e_data = d[m_holder*DW +: DW];
    end
    chk("grant_valid", 32'(bus.grant_valid), 32'(m_holder >= 0));
    chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
    chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
    chk("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(e_wr));
    chk("fifo_wr_data", 32'(bus.fifo_wr_data), 32'(e_data));
    chk("trunc_pulse", 32'(bus.trunc_pulse), 32'(m_trunc));
  endtask

  task automatic model_update(input logic [N-1:0] v, input logic [N-1:0] l, input logic full_s);
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_trunc = 1'b0;
    if (m_holder < 0) begin
      for (int k = 0; k < N; k++) begin
        if (v[(m_next + k) % N]) begin
          m_holder = (m_next + k) % N;
          m_gid    = m_holder;
          m_cnt    = 0;
          break;
        end
      end
    end else if (v[m_holder] && !full_s) begin
      m_cnt++;
      if (l[m_holder] || m_cnt == MAXB) begin
        m_trunc  = !l[m_holder];
        m_next   = (m_holder + 1) % N;
        m_holder = -1;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0]    v;
    logic [N-1:0]    l;
    logic [N-1:0]    rdy;
    logic [N*DW-1:0] d;
    logic            full_s;
    for (int i = 0; i < N; i++) begin
      v[i]          = (prd[i] != pwr[i]) && !bubble[i];
      d[i*DW +: DW] = pdat[i][prd[i] % QD];
      l[i]          = plast[i][prd[i] % QD];
    end
    full_s         = full;
    bus.req_valid  = v;
    bus.req_data   = d;
    bus.req_last   = l;
    bus.fifo_full  = full_s;
    #2;
    if (chk_en) compare_cycle(v, d, full_s);
    if (bus.fifo_wr_en === 1'b1) begin
      log_data.push_back(bus.fifo_wr_data);
      log_id.push_back(int'(bus.grant_id));
      log_cyc.push_back(cyc);
    end
    if (bus.trunc_pulse === 1'b1) begin
      trunc_cnt++;
      if (first_trunc_at < 0) first_trunc_at = log_data.size();
    end
    rdy = bus.req_ready;
    @(posedge clk);
    model_update(v, l, full_s);
    for (int i = 0; i < N; i++) begin
      if (v[i] && rdy[i]) prd[i]++;
    end
    cyc++;
    #1;
  endtask

  task automatic push_pkt(input int id, input int len, input logic [DW-1:0] base,
                          input bit with_last);
    for (int k = 0; k < len; k++) begin
      pdat[id][pwr[id] % QD]  = base + DW'(k);
      plast[id][pwr[id] % QD] = with_last && (k == len - 1);
      pwr[id]++;
    end
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      prd[i]    = 0;
      pwr[i]    = 0;
      bubble[i] = 1'b0;
    end
  endtask

  task automatic clear_log();
    log_data.delete();
    log_id.delete();
    log_cyc.delete();
    first_trunc_at = -1;
    trunc_cnt      = 0;
  endtask

  task automatic do_reset();
    flush();
    full   = 1'b0;
    rst_n  = 1'b0;
    chk_en = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    clear_log();
  endtask

  function automatic bit quiet();
    for (int i = 0; i < N; i++) if (prd[i] != pwr[i]) return 1'b0;
    return m_holder < 0;
  endfunction

  task automatic run_quiet(input string name, input int budget);
    int n = 0;
    while (!quiet() && n < budget) begin
      step();
      n++;
    end
    if (!quiet()) timeout(name);
    step();
  endtask

  task automatic wait_log(input string name, input int cnt, input int budget);
    int n = 0;
    while (log_data.size() < cnt && n < budget) begin
      step();
      n++;
    end
    if (log_data.size() < cnt) timeout(name);
  endtask

  initial begin
    int t0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < QD; k++) begin
        pdat[i][k]  = '0;
        plast[i][k] = 1'b0;
      end
    end
    model_reset();
    clear_log();

    // Reset values
    do_reset();
    chk("rst grant_valid", 32'(bus.grant_valid), 32'd0);
    chk("rst grant_id", 32'(bus.grant_id), 32'd0);
    chk("rst req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst fifo_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    chk("rst fifo_wr_data", 32'(bus.fifo_wr_data), 32'd0);
    chk("rst trunc_pulse", 32'(bus.trunc_pulse), 32'd0);

    // Single packet from requester 2
    push_pkt(2, 3, 8'hA1, 1'b1);
    t0 = cyc;
    run_quiet("single", 20);
    chk("single count", 32'(log_data.size()), 32'd3);
    chk("single latency", 32'(log_cyc[0] - t0), 32'd1);
    chk("single back-to-back", 32'(log_cyc[2] - log_cyc[0]), 32'd2);
    chk("single d0", 32'(log_data[0]), 32'hA1);
    chk("single d2", 32'(log_data[2]), 32'hA3);
    chk("single id", 32'(log_id[1]), 32'd2);
    clear_log();
    push_pkt(0, 1, 8'h50, 1'b1);
    push_pkt(3, 1, 8'h53, 1'b1);
    run_quiet("rr_ptr", 20);
    chk("rr_ptr after 2 first", 32'(log_id[0]), 32'd3);
    chk("rr_ptr after 2 second", 32'(log_id[1]), 32'd0);

    // Round-robin fairness
    do_reset();
    for (int i = 0; i < N; i++) push_pkt(i, 1, 8'(8'h10 * (i + 1)), 1'b1);
    for (int i = 0; i < N; i++) push_pkt(i, 1, 8'(8'h10 * (i + 1) + 1), 1'b1);
    run_quiet("fair", 40);
    for (int k = 0; k < 6; k++) chk("fair order", 32'(log_id[k]), 32'(k % N));
    chk("fair spacing", 32'(log_cyc[5] - log_cyc[0]), 32'd10);

    // Backpressure mid-packet
    do_reset();
    push_pkt(1, 4, 8'hB1, 1'b1);
    wait_log("bp first", 1, 10);
    full = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("bp stalled", 32'(log_data.size()), 32'd1);
    chk("bp grant held", 32'(bus.grant_valid), 32'd1);
    full = 1'b0;
    run_quiet("bp", 20);
    chk("bp count", 32'(log_data.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk("bp data", 32'(log_data[k]), 32'(8'hB1 + k));

    // Truncation after MAX_BEATS
    do_reset();
    push_pkt(0, 20, 8'h00, 1'b0);
    push_pkt(1, 1, 8'hC0, 1'b1);
    for (int k = 0; k < 40; k++) step();
    chk("trunc at", 32'(first_trunc_at), 32'd16);
    chk("trunc once", 32'(trunc_cnt), 32'd1);
    chk("trunc next id", 32'(log_id[16]), 32'd1);
    chk("trunc next data", 32'(log_data[16]), 32'hC0);
    chk("trunc resume", 32'(log_data[17]), 32'h10);
    chk("trunc total", 32'(log_data.size()), 32'd21);

    // Reset mid-packet
    do_reset();
    push_pkt(2, 5, 8'hD0, 1'b1);
    wait_log("rst mid", 2, 10);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst mid wr_en", 32'(bus.fifo_wr_en), 32'd0);
    chk("rst mid grant_valid", 32'(bus.grant_valid), 32'd0);
    flush();
    push_pkt(1, 1, 8'hE1, 1'b1);
    push_pkt(3, 1, 8'hE3, 1'b1);
    step();
    chk("rst rearb valid", 32'(bus.grant_valid), 32'd1);
    chk("rst rearb id", 32'(bus.grant_id), 32'd1);
    run_quiet("rst rearb", 20);

    // Bubble on the holder while another requester waits
    do_reset();
    push_pkt(3, 4, 8'hF0, 1'b1);
    wait_log("bubble first", 1, 10);
    bubble[3] = 1'b1;
    push_pkt(0, 1, 8'h0F, 1'b1);
    step();
    step();
    chk("bubble held", 32'(bus.grant_id), 32'd3);
    bubble[3] = 1'b0;
    run_quiet("bubble", 20);
    chk("bubble count", 32'(log_data.size()), 32'd5);
    chk("bubble 3 done", 32'(log_id[3]), 32'd3);
    chk("bubble 0 last", 32'(log_id[4]), 32'd0);

    // Randomized traffic, backpressure and bubbles
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ((pwr[i] - prd[i]) < 40 && $urandom_range(7) == 0) begin
          push_pkt(i, int'($urandom_range(20, 1)), 8'($urandom), $urandom_range(7) != 0);
        end
        bubble[i] = ($urandom_range(7) == 0);
      end
      full = ($urandom_range(3) == 0);
      if ($urandom_range(999) == 0) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
